// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin front end sharing one multiplier, with an in-order tag FIFO routing results back
module booth_mult_arbiter #(
  parameter int WIDTH = 16,
  parameter int NUM_REQ = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     req_b,
  input  logic [NUM_REQ*2-1:0]         req_mode,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [2*WIDTH-1:0]           resp_product,
  output logic                         mul_rst_n,
  output logic                         mul_start,
  output logic [WIDTH-1:0]             mul_a,
  output logic [WIDTH-1:0]             mul_b,
  output logic [1:0]                   mul_mode,
  input  logic [2*WIDTH-1:0]           mul_product,
  input  logic                         mul_done,
  input  logic                         mul_busy,
  output logic [$clog2(TAG_DEPTH):0]   inflight,
  output logic                         err_unexpected
);
  localparam int TW = $clog2(NUM_REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(TAG_DEPTH);
  localparam logic [TW:0] NR = (TW+1)'(NUM_REQ);
  logic [TW-1:0] r_ptr, w_win;
  logic [TW-1:0] r_tags [TAG_DEPTH];
  logic [TW:0] w_idx;
  logic w_found, w_grant, w_pop, r_start, r_err;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_inflight;
  logic [WIDTH-1:0] r_a, r_b;
  logic [1:0] r_mode;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [2*WIDTH-1:0] r_prod;
  always_comb begin
    w_win = '0;
    w_found = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (TW+1)'(r_ptr) + (TW+1)'(k);
      w_idx = (w_idx >= NR) ? w_idx - NR : w_idx;
      if (!w_found && req_valid[w_idx[TW-1:0]]) begin
        w_found = 1'b1;
        w_win = w_idx[TW-1:0];
      end
    end
  end
  // no grant while a start is on the bus, so operands never change under it
  assign w_grant = w_found & ~mul_busy & (r_inflight != FULL) & ~r_start & ~rst;
  assign w_pop = mul_done & (r_inflight != '0);
  assign req_ready = w_grant ? NUM_REQ'(1) << w_win : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_start <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_mode <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_inflight <= '0;
      r_err <= 1'b0;
      r_resp_valid <= '0;
      r_prod <= '0;
    end else begin
      r_start <= w_grant;
      if (w_grant) begin
        r_a <= req_a[w_win*WIDTH +: WIDTH];
        r_b <= req_b[w_win*WIDTH +: WIDTH];
        r_mode <= req_mode[w_win*2 +: 2];
        r_tags[r_wp] <= w_win;
        r_wp <= r_wp + AW'(1);
        r_ptr <= (w_win == TW'(NUM_REQ-1)) ? '0 : w_win + TW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
        r_prod <= mul_product;
      end
      r_resp_valid <= w_pop ? NUM_REQ'(1) << r_tags[r_rp] : '0;
      r_inflight <= r_inflight + (AW+1)'(w_grant) - (AW+1)'(w_pop);
      r_err <= r_err | (mul_done & ~w_pop);
    end
  end
  assign mul_rst_n = ~rst;
  assign mul_start = r_start;
  assign mul_a = r_a;
  assign mul_b = r_b;
  assign mul_mode = r_mode;
  assign inflight = r_inflight;
  assign err_unexpected = r_err;
  assign resp_valid = r_resp_valid;
  assign resp_product = r_prod;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: scoreboard bench with a mock in-order multiplier and a behavioural arbiter model
module tb_booth_mult_arbiter;
  localparam int W = 16;
  localparam int N = 4;
  localparam int D = 8;
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [2*N-1:0] req_mode = '0;
  logic [N-1:0] req_ready, resp_valid;
  logic [2*W-1:0] resp_product;
  logic mul_rst_n, mul_start;
  logic [W-1:0] mul_a, mul_b;
  logic [1:0] mul_mode;
  logic [2*W-1:0] mul_product = '0;
  logic mul_done = 0, mul_busy = 0;
  logic [3:0] inflight;
  logic err_unexpected;

  booth_mult_arbiter #(.WIDTH(W), .NUM_REQ(N), .TAG_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_mode(req_mode), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_product(resp_product), .mul_rst_n(mul_rst_n), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_mode(mul_mode), .mul_product(mul_product),
    .mul_done(mul_done), .mul_busy(mul_busy), .inflight(inflight),
    .err_unexpected(err_unexpected));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m);
    longint x, y;
    x = m[1] ? longint'($signed(a)) : longint'(a);
    y = m[0] ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  // mock multiplier: in-order results, random latency and busy
  logic [31:0] mq[$];
  bit mock_auto = 1, busy_rand = 0;
  int pop_req = 0, pop_ack = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mq.delete();
      mul_done = 0;
    end else begin
      if (pop_req != pop_ack) begin
        pop_ack = pop_req;
        mul_done = 1;
        if (mq.size() != 0) mul_product = mq.pop_front();
        else mul_product = $urandom;
      end else if (mock_auto && mq.size() != 0 && $urandom_range(0, 2) != 0) begin
        mul_done = 1;
        mul_product = mq.pop_front();
      end else begin
        mul_done = 0;
        mul_product = $urandom;
      end
      if (mul_start) mq.push_back(ref_mul(mul_a, mul_b, mul_mode));
    end
    mul_busy = busy_rand && ($urandom_range(0, 3) == 0);
  end

  // behavioural model and scoreboard
  int exq_tag[$];
  logic [31:0] exq_prod[$];
  int glog[$];
  int m_infl = 0, m_ptr = 0, m_tag = 0, win, n_grants = 0;
  bit m_start = 0, m_due = 0, m_err = 0, rst_e = 0;
  logic [31:0] m_prod = 0, m_last = 0;
  logic [15:0] m_a = 0, m_b = 0;
  logic [1:0] m_m = 0;
  logic [N-1:0] exp_rdy, hs_mask = '0;

  always @(posedge clk) rst_e <= rst;

  always @(negedge clk) begin
    chk("mul_rst_n", mul_rst_n, !rst);
    if (rst_e) begin
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_product", resp_product, 0);
      chk("rst_mul_start", mul_start, 0);
      chk("rst_mul_ops", {mul_a, mul_b, mul_mode}, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_err", err_unexpected, 0);
      m_infl = 0; m_ptr = 0; m_start = 0; m_due = 0; m_err = 0; m_last = 0;
      m_a = 0; m_b = 0; m_m = 0;
      exq_tag.delete(); exq_prod.delete();
    end
    win = -1;
    if (!rst && req_valid != 0 && !mul_busy && m_infl < D && !m_start)
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    exp_rdy = (win < 0) ? '0 : N'(1 << win);
    chk("req_ready", req_ready, exp_rdy);
    chk("inflight", inflight, m_infl);
    chk("mul_start", mul_start, m_start);
    chk("mul_ops", {mul_a, mul_b, mul_mode}, {m_a, m_b, m_m});
    chk("err_unexpected", err_unexpected, m_err);
    if (m_due) begin
      chk("resp_valid", resp_valid, 1 << m_tag);
      m_last = m_prod;
    end else chk("resp_valid_idle", resp_valid, 0);
    chk("resp_product", resp_product, m_last);
    m_due = 0;
    if (mul_done && !rst) begin
      if (m_infl > 0) begin
        m_tag = exq_tag.pop_front();
        m_prod = exq_prod.pop_front();
        m_due = 1;
        m_infl--;
      end else m_err = 1;
    end
    hs_mask = req_valid & req_ready;
    m_start = (win >= 0);
    if (win >= 0) begin
      m_a = req_a[win*W +: W];
      m_b = req_b[win*W +: W];
      m_m = req_mode[win*2 +: 2];
      exq_tag.push_back(win);
      exq_prod.push_back(ref_mul(m_a, m_b, m_m));
      glog.push_back(win);
      m_ptr = (win + 1) % N;
      m_infl++;
      n_grants++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic new_ops(input int i);
    req_a[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
    req_b[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
    req_mode[i*2 +: 2] = 2'($urandom);
  endtask

  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] m);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_mode[i*2 +: 2] = m;
    req_valid[i] = 1;
    for (int c = 0; c < 50; c++) begin
      step();
      if (hs_mask[i]) break;
    end
    chk("issue_handshake", hs_mask[i], 1);
    req_valid[i] = 0;
  endtask

  task automatic wait_resp(input string nm, input logic [N-1:0] mask, input logic [31:0] prod);
    for (int c = 0; c < 50; c++) begin
      if (resp_valid != 0) break;
      step();
    end
    chk({nm, "_valid"}, resp_valid, mask);
    chk({nm, "_product"}, resp_product, prod);
  endtask

  task automatic drain(input string nm);
    for (int c = 0; c < 300; c++) begin
      if (inflight == 0 && mq.size() == 0 && !mul_done) break;
      step();
    end
    step();
    step();
    chk(nm, inflight, 0);
  endtask

  int gbase, base;
  logic [N-1:0] seen;
  initial begin
    repeat (3) step();
    rst = 0;
    // contention from reset: strict rotation
    gbase = glog.size();
    req_valid = '1;
    for (int i = 0; i < N; i++) new_ops(i);
    for (int c = 0; c < 100 && glog.size() < gbase + 8; c++) begin
      step();
      for (int i = 0; i < N; i++) if (hs_mask[i]) new_ops(i);
    end
    chk("rr_count", glog.size() >= gbase + 8, 1);
    for (int k = 0; k < 8; k++) chk("rr_order", glog[gbase + k], k % N);
    req_valid = '0;
    drain("drain_rr");
    // single request
    mock_auto = 0;
    issue(0, 16'd10, 16'd10, 2'b11);
    chk("single_start", mul_start, 1);
    chk("single_mul_a", mul_a, 16'd10);
    mock_auto = 1;
    wait_resp("single", 4'b0001, 32'd100);
    drain("drain_single");
    // mixed signs, results in issue order
    mock_auto = 0;
    issue(2, 16'h8000, 16'd1, 2'b11);
    issue(1, 16'hFFFF, 16'd2, 2'b00);
    mock_auto = 1;
    wait_resp("mixed_r2", 4'b0100, 32'hFFFF8000);
    step();
    wait_resp("mixed_r1", 4'b0010, 32'd131070);
    drain("drain_mixed");
    // full tag FIFO
    mock_auto = 0;
    req_valid = '1;
    for (int c = 0; c < 80 && inflight != 4'(D); c++) step();
    chk("full_inflight", inflight, D);
    for (int c = 0; c < 3; c++) begin
      chk("full_blocked", req_ready, 0);
      step();
    end
    pop_req++;
    step();
    chk("full_pop_cycle_done", mul_done, 1);
    chk("full_pop_cycle_blocked", req_ready, 0);
    step();
    chk("full_resume", req_ready != 0, 1);
    req_valid = '0;
    mock_auto = 1;
    drain("drain_full");
    // unexpected done
    pop_req++;
    step();
    step();
    chk("err_set", err_unexpected, 1);
    chk("err_no_resp", resp_valid, 0);
    chk("err_inflight", inflight, 0);
    // reset with three in flight
    mock_auto = 0;
    issue(0, 16'd3, 16'd5, 2'b00);
    issue(1, 16'd7, 16'd9, 2'b01);
    issue(2, 16'd11, 16'd13, 2'b10);
    step();
    chk("pre_rst_inflight", inflight, 3);
    rst = 1;
    step();
    step();
    rst = 0;
    chk("post_rst_inflight", inflight, 0);
    chk("post_rst_err", err_unexpected, 0);
    mock_auto = 1;
    seen = '0;
    repeat (10) begin
      step();
      seen |= resp_valid;
    end
    chk("post_rst_no_stale", seen, 0);
    // random burst
    busy_rand = 1;
    base = n_grants;
    for (int c = 0; c < 4000 && n_grants < base + 200; c++) begin
      for (int i = 0; i < N; i++)
        if (hs_mask[i] || !req_valid[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          new_ops(i);
        end
      step();
    end
    chk("rand_count", n_grants >= base + 200, 1);
    req_valid = '0;
    busy_rand = 0;
    drain("drain_rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_mult_arbiter.md
BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width of the shared multiplier.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter TAG_DEPTH, default 8, in-flight tag FIFO depth (power of 2).
REQ-004 SHALL have ports, in this order:
- clk  in  1  the single clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_a  in  NUM_REQ*WIDTH  multiplicands; slice i belongs to requester i.
- req_b  in  NUM_REQ*WIDTH  multipliers.
- req_mode  in  NUM_REQ*2  sign modes; bit1 = a signed, bit0 = b signed.
- req_ready  out  NUM_REQ  one-hot grant.
- resp_valid  out  NUM_REQ  one-hot result strobe.
- resp_product  out  2*WIDTH  result shared by all requesters.
- mul_rst_n  out  1  multiplier reset, equal to ~rst.
- mul_start  out  1  multiplier start.
- mul_a, mul_b  out  WIDTH  multiplier operands.
- mul_mode  out  2  multiplier sign_mode.
- mul_product  in  2*WIDTH  multiplier product.
- mul_done  in  1  multiplier result strobe.
- mul_busy  in  1  multiplier cannot accept a start.
- inflight  out  log2(TAG_DEPTH)+1  outstanding operation count.
- err_unexpected  out  1  sticky flag: mul_done arrived with no tag outstanding.

Function
REQ-005 SHALL issue a grant in a cycle only when all three hold: some req_valid bit is set, mul_busy=0, and inflight<TAG_DEPTH.
REQ-006 SHALL drive req_ready combinationally, one-hot, to the winning requester; a handshake is req_valid[i]&req_ready[i].
REQ-007 SHALL select the winner round-robin:
- search starts at the priority pointer;
- the pointer is 0 after reset;
- after each grant the pointer becomes (winner+1) mod NUM_REQ;
- the pointer does not move when no grant is issued.
REQ-008 SHALL, in the cycle after a handshake, drive mul_start=1 for exactly one cycle, with mul_a/mul_b/mul_mode holding the winner's slices captured at the handshake.
REQ-009 SHALL hold mul_a/mul_b/mul_mode stable when mul_start=0.
REQ-010 SHALL NOT grant in the cycle in which mul_start=1, so there are no back-to-back grants; sustained throughput is one operation per 2 cycles while mul_busy=0.
REQ-011 SHALL push the winner's index into the tag FIFO at the handshake cycle.
REQ-012 SHALL pop the tag FIFO on each mul_done.
REQ-013 SHALL treat the tag FIFO as in order, matching the multiplier's in-order completion.
REQ-014 SHALL, one cycle after mul_done, assert resp_valid[popped tag] for one cycle with resp_product = the mul_product registered at mul_done.
REQ-015 SHALL apply no backpressure on responses; requesters always accept them.
REQ-016 SHALL handle a push and a pop in the same cycle with inflight unchanged and FIFO order preserved.
REQ-017 SHALL block grants while inflight=TAG_DEPTH; a pop in that same cycle does not unblock a grant until the next cycle.
REQ-018 SHALL wrap the FIFO read and write pointers modulo TAG_DEPTH.
REQ-019 SHALL, on mul_done while inflight=0, set err_unexpected, leave inflight unchanged, and drive all resp_valid bits to 0.
REQ-020 SHALL hold resp_product at its last value when resp_valid=0.

Reset
REQ-021 SHALL, while rst=1, clear to 0 at each clock edge: req_ready, resp_valid, resp_product, mul_start, mul_a, mul_b, mul_mode, inflight, err_unexpected, the FIFO pointers and the priority pointer.
REQ-022 SHALL drive mul_rst_n=0 while rst=1.
REQ-023 SHALL discard in-flight operations on reset mid-operation; no resp_valid is produced for them after rst falls.

Verification
REQ-024 Single request: req0 a=10, b=10, mode=11, multiplier idle -> mul_start at handshake+1 with mul_a=10; resp_valid=0001 with resp_product=100 one cycle after mul_done.
REQ-025 Contention: all four requesters valid continuously from reset -> grant order 0,1,2,3,0,…; no requester granted twice before every other valid requester has been granted once.
REQ-026 Mixed signs: req2 a=-32768, b=1, mode=11 and req1 a=0xFFFF, b=2, mode=00 -> resp_product -32768 routed to requester 2 and 131070 routed to requester 1, in issue order.
REQ-027 Full FIFO: hold mul_done low with 8 issued -> inflight=8 and req_ready=0; one mul_done -> grant resumes the following cycle.
REQ-028 Error and reset: mul_done with inflight=0 -> err_unexpected=1 and no resp_valid; rst pulsed with 3 in flight -> inflight=0, err_unexpected=0, no stale resp_valid.
REQ-029 Random burst: 200 random operands and modes against a scoreboard using the behavioural multiplier model -> every result matches and is routed to the correct requester, and inflight returns to 0.
